// File: rtl/relu_seq.sv
// relu_seq: sequential activation controller for the systolic-array output path.
// Accepts one packed row of signed accumulator results, runs every lane through
// one shared ReLU / ReLU6-style clip datapath (one lane per cycle), then offers
// the activated row downstream with valid/ready flow control.
//
// Optional feature: define RELU_SEQ_CLIP_EN to build the clip-to-MAX_VAL mode.
// Without it, cfg_mode_i is ignored and every non-bypass row uses plain ReLU.
//
// Ports:
//   clk_i, rst_n_i            clock (rising edge), async active-low reset
//   cfg_mode_i, cfg_bypass_i  activation config, sampled at the input handshake
//   in_valid_i/in_ready_o     input row handshake; in_data_i packed lanes, in_last_i
//   out_valid_o/out_ready_i   output row handshake; out_data_o packed lanes, out_last_o
//   busy_o                    high while a row is being processed or presented
//   row_cnt_o                 rows delivered in the current tile
module relu_seq #(
  parameter int unsigned BITWIDTH  = 8,
  parameter int unsigned LANES     = 8,
  parameter int          THRESHOLD = 0,
  parameter int          MAX_VAL   = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      cfg_mode_i,
  input  logic                      cfg_bypass_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [LANES*BITWIDTH-1:0] in_data_i,
  input  logic                      in_last_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [LANES*BITWIDTH-1:0] out_data_o,
  output logic                      out_last_o,
  output logic                      busy_o,
  output logic [15:0]               row_cnt_o
);

  localparam int unsigned CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);
  localparam logic signed [BITWIDTH-1:0] THR = BITWIDTH'(THRESHOLD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     state_q;
  logic [CNT_W-1:0]           lane_cnt_q;
  logic signed [BITWIDTH-1:0] lane_q [LANES];
  logic                       last_q;
  logic                       bypass_q;
  logic [15:0]                row_cnt_q;
  logic signed [BITWIDTH-1:0] cur_lane;
  logic signed [BITWIDTH-1:0] act_res;

`ifdef RELU_SEQ_CLIP_EN
  localparam logic signed [BITWIDTH-1:0] MAXV = BITWIDTH'(MAX_VAL);
  logic mode_q;
`else
  logic unused_cfg;
  assign unused_cfg = cfg_mode_i ^ (MAX_VAL != 0);
`endif

  // Shared activation datapath acting on the lane selected by lane_cnt_q
  always_comb begin
    cur_lane = lane_q[lane_cnt_q];
    act_res  = cur_lane;
    if (!bypass_q) begin
      if (cur_lane > THR) begin
        act_res = cur_lane;
`ifdef RELU_SEQ_CLIP_EN
        if (mode_q && !(cur_lane < MAXV)) begin
          act_res = MAXV;
        end
`endif
      end else begin
        act_res = THR;
      end
    end
  end

  // Controller FSM with row buffer, lane counter and delivered-row counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      lane_cnt_q <= '0;
      last_q     <= 1'b0;
      bypass_q   <= 1'b0;
      row_cnt_q  <= '0;
`ifdef RELU_SEQ_CLIP_EN
      mode_q     <= 1'b0;
`endif
      for (int i = 0; i < int'(LANES); i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            for (int i = 0; i < int'(LANES); i++) begin
              lane_q[i] <= in_data_i[i*BITWIDTH +: BITWIDTH];
            end
            last_q     <= in_last_i;
            bypass_q   <= cfg_bypass_i;
`ifdef RELU_SEQ_CLIP_EN
            mode_q     <= cfg_mode_i;
`endif
            lane_cnt_q <= '0;
            state_q    <= PROC;
          end
        end
        PROC: begin
          lane_q[lane_cnt_q] <= act_res;
          if (lane_cnt_q == LAST_LANE) begin
            lane_cnt_q <= '0;
            state_q    <= DONE;
          end else begin
            lane_cnt_q <= lane_cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_q   <= IDLE;
            // The last row of a tile restarts the count for the next tile
            row_cnt_q <= last_q ? 16'd0 : row_cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from the state register or driven straight from flops
  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign out_last_o  = last_q;
  assign row_cnt_o   = row_cnt_q;

  for (genvar g = 0; g < int'(LANES); g++) begin : g_pack
    assign out_data_o[g*BITWIDTH +: BITWIDTH] = lane_q[g];
  end

endmodule
